// File: rtl/wishbone_master.sv
// Single-beat bus initiator: one strobed bus cycle per user command, with the
// result (read data or timeout error) returned over a valid/ready response port.
module wishbone_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              strb,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ack
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic       timed_out;

  assign cmd_ready = (state == IDLE) && !rst;
  assign timed_out = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid)        state_nxt = BUS;
      BUS:     if (ack || timed_out) state_nxt = RESP;
      RESP:    if (rsp_ready)        state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Bus fields are only loaded on accept, so they hold their last values while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      strb      <= 1'b0;
      we        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            strb  <= 1'b1;
            we    <= cmd_we;
            addr  <= cmd_addr;
            wdata <= cmd_wdata;
            cnt   <= '0;
          end
        end
        BUS: begin
          // ack takes priority over a timeout landing on the same edge
          if (ack) begin
            strb      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= we ? '0 : rdata;
          end else if (timed_out) begin
            strb      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_master.sv
// Directed bench for wishbone_master: reset, write, wait-state read, timeout,
// response backpressure and reset in the middle of a bus cycle.
module tb_wishbone_master;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              strb, we, ack;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata;

  int errors = 0;
  int checks = 0;

  wishbone_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .strb(strb), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock, returning at the following falling edge for sampling/driving
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cmd_valid = 1'b1; cmd_we = w; cmd_addr = a; cmd_wdata = d;
    chk("issue_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 8'hEE; cmd_wdata = 32'hCAFEF00D;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; rdata = '0; ack = 1'b0;
    @(negedge clk);

    // reset held for 3 cycles with a command pending
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_strb", 64'(strb), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    rst = 1'b0; cmd_valid = 1'b0;
    chk("rst_addr", 64'(addr), 64'd0);
    tick();
    chk("post_rst_ready", 64'(cmd_ready), 64'd1);

    // write, zero wait states
    issue(1'b1, 8'h10, 32'hDEADBEEF);
    chk("wr_strb", 64'(strb), 64'd1);
    chk("wr_we", 64'(we), 64'd1);
    chk("wr_addr", 64'(addr), 64'h10);
    chk("wr_wdata", 64'(wdata), 64'hDEADBEEF);
    chk("wr_busy", 64'(cmd_ready), 64'd0);
    ack = 1'b1; rdata = 32'h11111111;
    tick();
    ack = 1'b0;
    chk("wr_strb_drop", 64'(strb), 64'd0);
    chk("wr_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("wr_rsp_err", 64'(rsp_err), 64'd0);
    chk("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
    tick();
    chk("wr_done_valid", 64'(rsp_valid), 64'd0);
    chk("wr_done_ready", 64'(cmd_ready), 64'd1);
    chk("wr_hold_addr", 64'(addr), 64'h10);

    // read with ack on the third strobe cycle
    issue(1'b0, 8'h10, 32'h0);
    chk("rd_strb1", 64'(strb), 64'd1);
    chk("rd_we", 64'(we), 64'd0);
    tick();
    chk("rd_strb2", 64'(strb), 64'd1);
    chk("rd_addr_stable", 64'(addr), 64'h10);
    tick();
    chk("rd_strb3", 64'(strb), 64'd1);
    ack = 1'b1; rdata = 32'hDEADBEEF;
    tick();
    ack = 1'b0; rdata = 32'h0;
    chk("rd_strb_drop", 64'(strb), 64'd0);
    chk("rd_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rd_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    chk("rd_rsp_err", 64'(rsp_err), 64'd0);
    tick();

    // timeout: strobe high exactly TIMEOUT cycles
    issue(1'b0, 8'h20, 32'h0);
    for (int i = 0; i < TIMEOUT; i++) begin
      chk($sformatf("to_strb_%0d", i), 64'(strb), 64'd1);
      tick();
    end
    chk("to_strb_drop", 64'(strb), 64'd0);
    chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("to_rsp_err", 64'(rsp_err), 64'd1);
    chk("to_rsp_rdata", 64'(rsp_rdata), 64'd0);
    tick();
    issue(1'b1, 8'h30, 32'h00000030);
    chk("to_next_strb", 64'(strb), 64'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("to_next_err", 64'(rsp_err), 64'd0);
    chk("to_next_valid", 64'(rsp_valid), 64'd1);
    tick();

    // response backpressure, with a second command and a stray ack waiting
    rsp_ready = 1'b0;
    issue(1'b0, 8'h44, 32'h0);
    ack = 1'b1; rdata = 32'h12345678;
    tick();
    rdata = 32'h0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h55;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rdata", 64'(rsp_rdata), 64'h12345678);
      chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("bp_strb", 64'(strb), 64'd0);
      tick();
    end
    ack = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("bp_rel_valid", 64'(rsp_valid), 64'd0);
    chk("bp_idle_strb", 64'(strb), 64'd0);
    chk("bp_idle_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    chk("bp_next_strb", 64'(strb), 64'd1);
    chk("bp_next_addr", 64'(addr), 64'h55);
    ack = 1'b1; rdata = 32'hA5A5A5A5;
    tick();
    ack = 1'b0; rdata = 32'h0;
    chk("bp_next_rdata", 64'(rsp_rdata), 64'hA5A5A5A5);
    tick();

    // reset during the second strobe cycle of a read, then a late ack
    issue(1'b0, 8'h60, 32'h0);
    chk("mr_strb1", 64'(strb), 64'd1);
    tick();
    chk("mr_strb2", 64'(strb), 64'd1);
    rst = 1'b1;
    tick();
    chk("mr_strb", 64'(strb), 64'd0);
    chk("mr_valid", 64'(rsp_valid), 64'd0);
    chk("mr_ready", 64'(cmd_ready), 64'd0);
    rst = 1'b0; ack = 1'b1; rdata = 32'hFFFFFFFF;
    tick();
    ack = 1'b0;
    chk("mr_late_valid", 64'(rsp_valid), 64'd0);
    chk("mr_late_strb", 64'(strb), 64'd0);
    chk("mr_late_ready", 64'(cmd_ready), 64'd1);
    tick();
    chk("mr_final_valid", 64'(rsp_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
